// File: rtl/id_issue_buf_if.sv
// rtl/id_issue_buf_if.sv - fetch-side and decode-side stream handshake bundle for id_issue_buf
interface id_issue_buf_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst
  );

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/id_issue_buf.sv
// rtl/id_issue_buf.sv - fetch-to-decode issue FIFO with load-use interlock on the head entry
// Optional empty-buffer bypass of fetch straight to decode: define ID_BUF_BYPASS_EN.
module id_issue_buf #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  id_issue_buf_if.slave          bus,
  input  logic                   flush,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_waddr,
  output logic                   stallreq,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty;
  logic          head_hz;
  logic          push;
  logic          pop;

  // rs is inst[25:21], rt is inst[20:16]; r0 never creates a dependency
  function automatic logic load_use(input logic [INST_W-1:0] inst,
                                    input logic ld, input logic [4:0] wa);
    return ld && (wa != 5'd0) && ((wa == inst[25:21]) || (wa == inst[20:16]));
  endfunction

  assign empty        = (count_q == '0);
  assign head_hz      = load_use(inst_mem[rptr_q], ex_is_load, ex_waddr);
  assign bus.in_ready = (count_q != FULL_CNT);
  assign count        = count_q;

  always_comb begin
    bus.out_valid = !empty && !head_hz;
    stallreq      = !empty && head_hz;
    bus.out_pc    = empty ? '0 : pc_mem[rptr_q];
    bus.out_inst  = empty ? '0 : inst_mem[rptr_q];
    push          = bus.in_valid && bus.in_ready && !flush;
`ifdef ID_BUF_BYPASS_EN
    // an entry consumed on the bypass path is never written into storage
    if (!rst && empty && bus.in_valid && !flush &&
        !load_use(bus.in_inst, ex_is_load, ex_waddr)) begin
      bus.out_valid = 1'b1;
      bus.out_pc    = bus.in_pc;
      bus.out_inst  = bus.in_inst;
      stallreq      = 1'b0;
      push          = !bus.out_ready;
    end
`endif
    pop = !empty && bus.out_valid && bus.out_ready && !flush;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr_q]   <= bus.in_pc;
      inst_mem[wptr_q] <= bus.in_inst;
    end
  end
endmodule

// File: tb/tb_id_issue_buf.sv
// tb/tb_id_issue_buf.sv - scoreboard bench for id_issue_buf (directed scenarios then random traffic)
module tb_id_issue_buf;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       ex_is_load;
  logic [4:0] ex_waddr;
  logic       stallreq;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t q[$];

  id_issue_buf_if #(.PC_W(32), .INST_W(32)) bus ();

  id_issue_buf #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .ex_is_load (ex_is_load),
    .ex_waddr   (ex_waddr),
    .stallreq   (stallreq),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic dep(input logic [31:0] inst, input logic ld, input logic [4:0] wa);
    logic [4:0] rs, rt;
    rs = inst[25:21];
    rt = inst[20:16];
    return ld && wa != 0 && (wa == rs || wa == rt);
  endfunction

  // Reference model: a queue of accepted entries, evaluated once per cycle with inputs stable
  always @(negedge clk) begin
    int   n;
    logic ev, es, byp;
    logic [31:0] epc, einst;
    if (rst) begin
      q.delete();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_stallreq", 64'(stallreq), 64'd0);
      chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
    end else begin
      n = q.size();
      byp = 1'b0;
      if (n > 0) begin
        es = dep(q[0].inst, ex_is_load, ex_waddr);
        ev = !es;
        epc = q[0].pc;
        einst = q[0].inst;
      end else begin
        es = 1'b0;
        ev = 1'b0;
        epc = '0;
        einst = '0;
`ifdef ID_BUF_BYPASS_EN
        if (bus.in_valid && !flush && !dep(bus.in_inst, ex_is_load, ex_waddr)) begin
          byp = 1'b1;
          ev = 1'b1;
          epc = bus.in_pc;
          einst = bus.in_inst;
        end
`endif
      end
      chk("count", 64'(count), 64'(n));
      chk("in_ready", 64'(bus.in_ready), 64'(n != DEPTH));
      chk("out_valid", 64'(bus.out_valid), 64'(ev));
      chk("stallreq", 64'(stallreq), 64'(es));
      chk("out_pc", 64'(bus.out_pc), 64'(epc));
      chk("out_inst", 64'(bus.out_inst), 64'(einst));
      if (flush) begin
        q.delete();
      end else begin
        if (ev && bus.out_ready && !byp) void'(q.pop_front());
        if (bus.in_valid && n != DEPTH && !(byp && bus.out_ready))
          q.push_back('{pc: bus.in_pc, inst: bus.in_inst});
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl, input logic ld, input logic [4:0] wa);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.out_ready = ordy;
    flush         = fl;
    ex_is_load    = ld;
    ex_waddr      = wa;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.out_ready = 1'b0;
    flush = 1'b0; ex_is_load = 1'b0; ex_waddr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // fill to full, attempt a fifth push, then drain in order
    for (int i = 0; i < 5; i++) drive(1'b1, 32'(i * 4), 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    idle();

    // load-use stall on rt, then release
    drive(1'b1, 32'h100, 32'h8C430000, 1'b0, 1'b0, 1'b0, 5'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd3);

    // waddr 0 never stalls
    drive(1'b1, 32'h200, 32'h8C030000, 1'b0, 1'b0, 1'b0, 5'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0);
    idle();

    // flush at count 3 wins over a same-cycle push
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h300 + 32'(i * 4), 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    drive(1'b1, 32'h3F0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);
    idle();

    // steady push+pop at count 2 across several pointer wraps
    for (int i = 0; i < 2; i++) drive(1'b1, 32'h400 + 32'(i * 4), 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int i = 2; i < 12; i++) drive(1'b1, 32'h400 + 32'(i * 4), 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 2; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);

    // empty buffer with producer and consumer both ready
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h500 + 32'(i * 4), 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    idle();

    // asynchronous reset between edges at count 3
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h600 + 32'(i * 4), 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_out_pc", 64'(bus.out_pc), 64'd0);
    chk("async_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 32'h700, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);

    // random traffic with registers 0..3 so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] inst;
      inst = {6'h23, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      drive(1'($urandom_range(0, 3) != 0), $urandom, inst, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 24) == 0), 1'($urandom), 5'($urandom_range(0, 3)));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
